// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types, frame geometry and RGB565->RGB332 packing for the camera write path
package cam_pkg;

    // Capture FSM states
    typedef enum logic [1:0] {
        S_WAIT_FRAME = 2'd0,
        S_WAIT_START = 2'd1,
        S_BYTE_HI    = 2'd2,
        S_BYTE_LO    = 2'd3
    } cam_state_e;

    // Default frame geometry (QQVGA)
    localparam int H_PIX_DEF   = 160;
    localparam int V_LINES_DEF = 120;
    localparam int NPIX        = H_PIX_DEF * V_LINES_DEF;

    // hi = R4..R0 G5G4G3, lo = G2G1G0 B4..B0; keep the top bits of each channel
    function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

endpackage

// File: rtl/rgb565_pack.sv
// rtl/rgb565_pack.sv - combinational RGB565 byte pair to RGB332 pixel
module rgb565_pack
    import cam_pkg::*;
(
    input  logic [7:0] hi,
    input  logic [7:0] lo,
    output logic [7:0] px332
);

    // Pure packing; shared with the VGA-side pattern generator
    always_comb begin
        px332 = rgb565_to_332(hi, lo);
    end

endmodule

// File: rtl/cam_frame_writer.sv
// rtl/cam_frame_writer.sv - OV7670 RGB565 capture into the frame buffer write port as RGB332
module cam_frame_writer
    import cam_pkg::*;
#(
    parameter int AW      = 15,
    parameter int DW      = 8,
    parameter int H_PIX   = 160,
    parameter int V_LINES = 120
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_wr,
    output logic          frame_done,
    output logic          overflow
);

    // Counter is one bit wider than the address so it can reach NPIX
    localparam int          NPIX_P   = H_PIX * V_LINES;
    localparam logic [AW:0] NPIX_CNT = (AW+1)'(NPIX_P);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    cam_state_e    state;
    cam_state_e    state_nxt;
    logic [7:0]    hi_byte;
    logic [AW:0]   pix_cnt;
    logic [7:0]    packed_px;

    logic          frame_start;
    logic          latch_hi;
    logic          pixel_done;
    logic          frame_end;

    rgb565_pack u_pack (
        .hi    (hi_byte),
        .lo    (px_data),
        .px332 (packed_px)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT_FRAME;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: vsync high inside a frame ends it, ahead of any href activity
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT_FRAME: begin
                if (enable && vsync) begin
                    state_nxt = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (!vsync) begin
                    state_nxt = S_BYTE_HI;
                end
            end
            S_BYTE_HI: begin
                if (vsync) begin
                    state_nxt = enable ? S_WAIT_START : S_WAIT_FRAME;
                end else if (href) begin
                    state_nxt = S_BYTE_LO;
                end
            end
            S_BYTE_LO: begin
                // Without href the line ended mid-pixel; the hi byte is simply abandoned
                if (vsync) begin
                    state_nxt = enable ? S_WAIT_START : S_WAIT_FRAME;
                end else begin
                    state_nxt = S_BYTE_HI;
                end
            end
            default: begin
                state_nxt = S_WAIT_FRAME;
            end
        endcase
    end

    // Output decode: one-cycle event strobes for the datapath
    always_comb begin
        frame_start = 1'b0;
        latch_hi    = 1'b0;
        pixel_done  = 1'b0;
        frame_end   = 1'b0;
        case (state)
            S_WAIT_START: frame_start = !vsync;
            S_BYTE_HI: begin
                frame_end = vsync;
                latch_hi  = !vsync && href;
            end
            S_BYTE_LO: begin
                frame_end  = vsync;
                pixel_done = !vsync && href;
            end
            default: ;
        endcase
    end

    // Hold the first byte of the pixel until its partner arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_byte <= 8'h00;
        end else if (latch_hi) begin
            hi_byte <= px_data;
        end
    end

    // Pixel index and sticky overflow, both cleared at the VSYNC fall that starts a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            overflow <= 1'b0;
        end else if (frame_start) begin
            pix_cnt  <= '0;
            overflow <= 1'b0;
        end else if (pixel_done) begin
            if (pix_cnt < NPIX_CNT) begin
                pix_cnt <= pix_cnt + CNT_ONE;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    // Write port: strobe for one cycle per in-range pixel, address/data hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            mem_wr <= 1'b0;
            if (pixel_done && (pix_cnt < NPIX_CNT)) begin
                mem_wr   <= 1'b1;
                mem_addr <= pix_cnt[AW-1:0];
                mem_data <= DW'(packed_px);
            end
        end
    end

    // End-of-frame pulse on the VSYNC rise that closes a capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
        end
    end

endmodule
